// File: rtl/rl_desc_queue_if.sv
// rl_desc_queue_if: ingress tap and scheduler-side descriptor bus for rl_desc_queue.
// slave  = the descriptor queue itself; master = the environment around it.
`timescale 1ns/1ps
interface rl_desc_queue_if #(
  parameter int PRIO_WIDTH     = 3,
  parameter int LEN_WIDTH      = 16,
  parameter int APP_ID_WIDTH   = 4,
  parameter int DEPTH_LOG2     = 4,
  parameter int DROP_CNT_WIDTH = 32
);
  // ingress stream tap (monitor only) and parser descriptor fields
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic [PRIO_WIDTH-1:0]     s_desc_prio;
  logic [LEN_WIDTH-1:0]      s_desc_pk_len;
  logic [APP_ID_WIDTH-1:0]   s_desc_app_id;
  // scheduler-side show-ahead descriptor handshake
  logic                      m_desc_valid;
  logic                      m_desc_ready;
  logic [PRIO_WIDTH-1:0]     m_desc_prio;
  logic [LEN_WIDTH-1:0]      m_desc_pk_len;
  logic [APP_ID_WIDTH-1:0]   m_desc_app_id;
  // status
  logic [DEPTH_LOG2:0]       fifo_level;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_desc_prio, s_desc_pk_len, s_desc_app_id,
    input  m_desc_ready,
    output m_desc_valid, m_desc_prio, m_desc_pk_len, m_desc_app_id,
    output fifo_level, drop_count
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_desc_prio, s_desc_pk_len, s_desc_app_id,
    output m_desc_ready,
    input  m_desc_valid, m_desc_prio, m_desc_pk_len, m_desc_app_id,
    input  fifo_level, drop_count
  );
endinterface

// File: rtl/rl_desc_queue.sv
// rl_desc_queue: captures the RingLeader parser descriptor {prio, pk_len, app_id}
// at packet start and buffers it in a show-ahead FIFO for the scheduler.
// Optional build macro RL_DESC_COMMIT_ON_EOP_EN: hold the descriptor in a staging
// register and commit it to the FIFO on the packet's last beat instead of its first.
// All outputs come straight from registers; the head register is loaded with the
// next-cycle head so a descriptor is visible one cycle after it is pushed.
`timescale 1ns/1ps
module rl_desc_queue #(
  parameter int PRIO_WIDTH     = 3,
  parameter int LEN_WIDTH      = 16,
  parameter int APP_ID_WIDTH   = 4,
  parameter int DEPTH_LOG2     = 4,
  parameter int DROP_CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rl_desc_queue_if.slave bus
);

  localparam int DATA_W = PRIO_WIDTH + LEN_WIDTH + APP_ID_WIDTH;
  localparam int PTR_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 2 ** DEPTH_LOG2;

  localparam logic [PTR_W-1:0]          PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]          PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [DATA_W-1:0]         DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  logic                      sop_r;
  logic [DATA_W-1:0]         in_data_s;
  logic                      push_req_s;
  logic [DATA_W-1:0]         push_data_s;

  logic [DATA_W-1:0]         mem_r [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [PTR_W-1:0]          wr_ptr_nxt_s;
  logic [PTR_W-1:0]          rd_ptr_nxt_s;
  logic                      full_s;
  logic                      pop_s;
  logic                      push_acc_s;
  logic                      drop_s;
  logic                      valid_nxt_s;
  logic [DATA_W-1:0]         head_nxt_s;

  logic                      m_valid_r;
  logic [DATA_W-1:0]         m_data_r;
  logic [PTR_W-1:0]          level_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;

  assign in_data_s = {bus.s_desc_prio, bus.s_desc_pk_len, bus.s_desc_app_id};

  // Start-of-packet flag: the beat after a tlast beat (or after reset) is a first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_r <= 1'b1;
    end else if (bus.s_axis_tvalid) begin
      sop_r <= bus.s_axis_tlast;
    end else begin
      sop_r <= sop_r;
    end
  end

`ifdef RL_DESC_COMMIT_ON_EOP_EN
  logic              staged_r;
  logic [DATA_W-1:0] stage_data_r;

  // Staging register: hold a multi-beat packet's descriptor until its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged_r     <= 1'b0;
      stage_data_r <= DATA_ZERO;
    end else if (bus.s_axis_tvalid && sop_r && !bus.s_axis_tlast) begin
      staged_r     <= 1'b1;
      stage_data_r <= in_data_s;
    end else if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
      staged_r     <= 1'b0;
      stage_data_r <= stage_data_r;
    end else begin
      staged_r     <= staged_r;
      stage_data_r <= stage_data_r;
    end
  end

  // Commit on tlast: single-beat packets go straight in, longer ones from staging.
  always_comb begin
    push_req_s  = 1'b0;
    push_data_s = in_data_s;
    if (bus.s_axis_tvalid && bus.s_axis_tlast && sop_r) begin
      push_req_s  = 1'b1;
      push_data_s = in_data_s;
    end else if (bus.s_axis_tvalid && bus.s_axis_tlast && staged_r) begin
      push_req_s  = 1'b1;
      push_data_s = stage_data_r;
    end else begin
      push_req_s  = 1'b0;
      push_data_s = in_data_s;
    end
  end
`else
  // Commit on the first beat using the parser fields sampled in that cycle.
  always_comb begin
    push_req_s  = 1'b0;
    push_data_s = in_data_s;
    if (bus.s_axis_tvalid && sop_r) begin
      push_req_s = 1'b1;
    end else begin
      push_req_s = 1'b0;
    end
  end
`endif

  // Push/pop arbitration and next-cycle head selection.
  always_comb begin
    full_s       = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                   (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    pop_s        = m_valid_r && bus.m_desc_ready;
    push_acc_s   = push_req_s && (!full_s || pop_s);
    drop_s       = push_req_s && full_s && !pop_s;
    wr_ptr_nxt_s = push_acc_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    valid_nxt_s  = (rd_ptr_nxt_s != wr_ptr_nxt_s);
    // The new head may be the entry being written this very cycle.
    if (push_acc_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = push_data_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[DEPTH_LOG2-1:0]];
    end
  end

  // Descriptor storage: plain registers, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data_s;
    end else begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= mem_r[wr_ptr_r[DEPTH_LOG2-1:0]];
    end
  end

  // Pointers, occupancy and registered show-ahead head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      level_r   <= PTR_ZERO;
      m_valid_r <= 1'b0;
      m_data_r  <= DATA_ZERO;
    end else begin
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      level_r   <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      m_valid_r <= valid_nxt_s;
      if (valid_nxt_s) begin
        m_data_r <= head_nxt_s;
      end else begin
        m_data_r <= m_data_r;
      end
    end
  end

  // Saturating count of descriptors lost to a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
    end else if (drop_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + DROP_ONE;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.m_desc_valid = m_valid_r;
  assign {bus.m_desc_prio, bus.m_desc_pk_len, bus.m_desc_app_id} = m_data_r;
  assign bus.fifo_level   = level_r;
  assign bus.drop_count   = drop_cnt_r;

endmodule

// File: tb/tb_rl_desc_queue.sv
// tb_rl_desc_queue: directed self-checking bench for rl_desc_queue.
`timescale 1ns/1ps
module tb_rl_desc_queue;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  rl_desc_queue_if #(.PRIO_WIDTH(3), .LEN_WIDTH(16), .APP_ID_WIDTH(4),
                     .DEPTH_LOG2(4), .DROP_CNT_WIDTH(32)) bus ();

  rl_desc_queue #(.PRIO_WIDTH(3), .LEN_WIDTH(16), .APP_ID_WIDTH(4),
                  .DEPTH_LOG2(4), .DROP_CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wire [22:0] head_w = {bus.m_desc_prio, bus.m_desc_pk_len, bus.m_desc_app_id};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] mk(input int k);
    logic [31:0] kk;
    kk = k;
    return {kk[2:0], 16'h0100 + kk[15:0], kk[3:0]};
  endfunction

  task automatic drive(input logic v, input logic l, input logic [22:0] d);
    bus.s_axis_tvalid = v;
    bus.s_axis_tlast  = l;
    bus.s_desc_prio   = d[22:20];
    bus.s_desc_pk_len = d[19:4];
    bus.s_desc_app_id = d[3:0];
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 23'd0);
    bus.m_desc_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [22:0] sb[$];
  logic [22:0] got;
  int          n_seen;
  int          pushed;
  int          exp_drop;
  int          sz;
  logic        p;
  logic        r;
  logic        pop;

  initial begin
    n_total = 0;
    n_pass  = 0;
    do_reset();

    // reset state
    check("rst_valid", bus.m_desc_valid, 0);
    check("rst_head", head_w, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_drop", bus.drop_count, 0);

    // single 3-beat packet, ready held high
    bus.m_desc_ready = 1'b1;
    drive(1'b1, 1'b0, {3'd5, 16'h05DC, 4'd3});
    step();
`ifdef RL_DESC_COMMIT_ON_EOP_EN
    check("p3_b0_valid", bus.m_desc_valid, 0);
    drive(1'b1, 1'b0, mk(7));
    step();
    check("p3_b1_valid", bus.m_desc_valid, 0);
    drive(1'b1, 1'b1, mk(9));
    step();
    check("p3_valid", bus.m_desc_valid, 1);
    check("p3_head", head_w, {3'd5, 16'h05DC, 4'd3});
    check("p3_level1", bus.fifo_level, 1);
    drive(1'b0, 1'b0, 23'd0);
    step();
    check("p3_valid_off", bus.m_desc_valid, 0);
    check("p3_level0", bus.fifo_level, 0);
`else
    check("p3_valid", bus.m_desc_valid, 1);
    check("p3_head", head_w, {3'd5, 16'h05DC, 4'd3});
    check("p3_level1", bus.fifo_level, 1);
    drive(1'b1, 1'b0, mk(7));
    step();
    check("p3_valid_off", bus.m_desc_valid, 0);
    check("p3_level0", bus.fifo_level, 0);
    drive(1'b1, 1'b1, mk(9));
    step();
    check("p3_b2_valid", bus.m_desc_valid, 0);
    drive(1'b0, 1'b0, 23'd0);
    step();
    check("p3_idle_valid", bus.m_desc_valid, 0);
`endif

    // fill with 16 single-beat packets, 17th is dropped, then drain in order
    bus.m_desc_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, mk(i));
      step();
    end
    check("fill_level16", bus.fifo_level, 16);
    check("fill_drop0", bus.drop_count, 0);
    drive(1'b1, 1'b1, mk(16));
    step();
    drive(1'b0, 1'b0, 23'd0);
    check("fill_drop1", bus.drop_count, 1);
    check("fill_level_hold", bus.fifo_level, 16);
    bus.m_desc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_valid_%0d", i), bus.m_desc_valid, 1);
      check($sformatf("drain_head_%0d", i), head_w, mk(i));
      step();
    end
    check("drain_empty", bus.m_desc_valid, 0);
    check("drain_level0", bus.fifo_level, 0);

    // full queue, SOP beat coinciding with a pop is accepted
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, mk(i));
      step();
    end
    check("fp_level16", bus.fifo_level, 16);
    bus.m_desc_ready = 1'b1;
    drive(1'b1, 1'b1, mk(16));
    step();
    drive(1'b0, 1'b0, 23'd0);
    check("fp_drop0", bus.drop_count, 0);
    check("fp_level16b", bus.fifo_level, 16);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("fp_head_%0d", i), head_w, mk(i));
      step();
    end
    check("fp_empty", bus.m_desc_valid, 0);

    // backpressure: ready 1,0,0,1 with three queued
    bus.m_desc_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, mk(i));
      step();
    end
    drive(1'b0, 1'b0, 23'd0);
    check("bp_level3", bus.fifo_level, 3);
    bus.m_desc_ready = 1'b1;
    check("bp_head_a", head_w, mk(1));
    step();
    bus.m_desc_ready = 1'b0;
    check("bp_head_b", head_w, mk(2));
    step();
    check("bp_head_c", head_w, mk(2));
    check("bp_valid_c", bus.m_desc_valid, 1);
    step();
    bus.m_desc_ready = 1'b1;
    check("bp_head_d", head_w, mk(2));
    step();
    check("bp_head_e", head_w, mk(3));
    step();
    check("bp_empty", bus.m_desc_valid, 0);
    check("bp_level0", bus.fifo_level, 0);

    // wrap: 40 accepted descriptors with random ready against a queue model
    pushed   = 0;
    exp_drop = 0;
    sb.delete();
    for (int cyc = 0; cyc < 2000 && (pushed < 40 || sb.size() != 0); cyc++) begin
      sz = sb.size();
      check("wrap_valid", bus.m_desc_valid, (sz != 0));
      if (sz != 0) check("wrap_head", head_w, sb[0]);
      check("wrap_level", bus.fifo_level, sz);
      check("wrap_level_max", (bus.fifo_level <= 16), 1);
      p = (pushed < 40) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      drive(p, 1'b1, mk(100 + pushed));
      bus.m_desc_ready = r;
      pop = (sz != 0) && r;
      if (p) begin
        if (sz < 16 || pop) begin
          sb.push_back(mk(100 + pushed));
          pushed++;
        end else begin
          exp_drop++;
        end
      end
      if (pop) void'(sb.pop_front());
      step();
    end
    drive(1'b0, 1'b0, 23'd0);
    check("wrap_all_pushed", pushed, 40);
    check("wrap_sb_empty", sb.size(), 0);
    check("wrap_drops", bus.drop_count, exp_drop);

    // reset in the middle of a 4-beat packet with two entries queued
    bus.m_desc_ready = 1'b0;
    drive(1'b1, 1'b1, mk(50));
    step();
    drive(1'b1, 1'b1, mk(51));
    step();
    drive(1'b1, 1'b0, mk(60));
    step();
    drive(1'b1, 1'b0, mk(61));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", bus.m_desc_valid, 0);
    check("mr_level", bus.fifo_level, 0);
    check("mr_drop", bus.drop_count, 0);
    drive(1'b0, 1'b0, 23'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.m_desc_ready = 1'b1;
    n_seen = 0;
    got    = 23'd0;
    for (int c = 0; c < 8; c++) begin
      if (bus.m_desc_valid && bus.m_desc_ready) begin
        n_seen++;
        got = head_w;
      end
      if (c == 0) drive(1'b1, 1'b0, mk(70));
      else if (c == 1) drive(1'b1, 1'b1, mk(71));
      else drive(1'b0, 1'b0, 23'd0);
      step();
    end
    check("mr_count", n_seen, 1);
    check("mr_desc", got, mk(70));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rl_desc_queue.md
Name: rl_desc_queue

Overview:
- Sits directly downstream of the RingLeader header parser, on the same ingress AXI stream tap.
- Captures the parser's per-packet descriptor (prio, packet length, app id) on the packet's first beat and buffers it in a show-ahead FIFO.
- Presents the buffered descriptors to the scheduler through a valid/ready handshake.
- Counts descriptors dropped because the FIFO was full.

Parameters:
- PRIO_WIDTH, 3, width of descriptor priority field
- LEN_WIDTH, 16, width of descriptor packet-length field
- APP_ID_WIDTH, 4, width of descriptor app id field
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16)
- DROP_CNT_WIDTH, 32, width of drop counter

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  ingress beat valid (monitor only; no tready, the stream is never stalled)
- s_axis_tlast  in  1  ingress last beat
- s_desc_prio  in  PRIO_WIDTH  parser priority, valid during first beat
- s_desc_pk_len  in  LEN_WIDTH  parser length (IP len + 14), valid during first beat
- s_desc_app_id  in  APP_ID_WIDTH  parser app id, valid during first beat
- m_desc_valid  out  1  head descriptor valid
- m_desc_ready  in  1  consumer accepts head
- m_desc_prio  out  PRIO_WIDTH  head priority
- m_desc_pk_len  out  LEN_WIDTH  head length
- m_desc_app_id  out  APP_ID_WIDTH  head app id
- fifo_level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped descriptors

Behaviour:
- Reset (rst_n low, async assert, sync deassert by system):
  - sop_reg=1; FIFO emptied; m_desc_valid=0; m_desc_* = 0; fifo_level=0; drop_count=0.
- SOP tracking:
  - sop_reg set on (tvalid && tlast).
  - sop_reg cleared on (tvalid && !tlast && sop_reg).
  - A single-beat packet (tvalid && tlast && sop_reg) is a SOP beat and leaves sop_reg=1.
- Capture: push_req = tvalid && sop_reg. Data word = {prio, pk_len, app_id} sampled in that same cycle.
- Push:
  - If not full, or pop in the same cycle, write to the tail, increment the write pointer, and accept.
  - If full with no concurrent pop, drop the descriptor; drop_count += 1, saturating at all-ones.
- Pop: m_desc_valid && m_desc_ready advances the read pointer.
- Latency: descriptor visible on m_desc_* with m_desc_valid=1 exactly one cycle after its SOP beat when the FIFO was empty (no combinational input-to-output path).
- Show-ahead: m_desc_* holds the head entry whenever m_desc_valid=1. It must stay stable while valid && !ready.
- fifo_level is registered; it updates the cycle after push/pop. Push+pop in the same cycle leaves it unchanged.
- Pointers: DEPTH_LOG2+1 bits with an extra wrap bit. Full = MSBs differ and low bits equal; empty = pointers equal. Wrap-around is seamless.
- Pop when empty: ignored (m_desc_valid=0, so no pop occurs).
- Reset mid-packet: sop_reg returns to 1. The next beat of the interrupted packet is treated as SOP and produces a descriptor; this is defined, accepted behaviour.
- Storage is inferred distributed RAM/registers; only the pointers, level and counter are reset.

Optional Feature:
- Macro: RL_DESC_COMMIT_ON_EOP_EN.
- Defined:
  - The SOP descriptor is held in a staging register with a staged flag; it is pushed on the packet's tlast beat, not the SOP beat.
  - A single-beat packet is pushed in its own cycle.
  - Full/drop decision is made at tlast.
  - Latency becomes one cycle after the tlast beat.
  - Reset clears the staged flag.
- Undefined: push at the SOP beat as above; no staging register.

Test Plan:
- Single 3-beat packet (prio=5, len=0x05DC, app=3), m_desc_ready=1:
  - m_desc_valid=1 one cycle after beat 0 with {5,0x05DC,3}, for exactly one cycle.
  - fifo_level 0->1->0.
  - With RL_DESC_COMMIT_ON_EOP_EN, valid appears one cycle after beat 2 instead.
- 16 back-to-back single-beat packets with app ids 0..15, ready=0:
  - fifo_level reaches 16.
  - A 17th packet increments drop_count to 1.
  - Then ready=1 drains ids 0..15 in order, one per cycle.
- FIFO full, 17th SOP beat in the same cycle as a pop:
  - Descriptor accepted, drop_count stays 0, fifo_level stays 16.
- Backpressure: ready toggles 1,0,0,1 while 3 descriptors are queued:
  - m_desc_* stable during the ready=0 cycles.
  - Order preserved, no duplicates or losses.
- Wrap: push/pop 40 descriptors with random ready (pointers wrap twice):
  - Scoreboard matches exactly; level never exceeds 16.
- rst_n asserted mid-packet (beat 1 of 4) with 2 entries queued:
  - m_desc_valid=0, fifo_level=0, drop_count=0 immediately.
  - After release, the next beat yields one descriptor.
